vga_timing_gen: RTL and testbench

//  Raster timing generator for the VGA output path. Clocked by the 25 MHz pixel

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 55 +++++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_pkg - default 640x480@60 raster constants shared by the VGA path
// Rev 1.0
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int C_H_VISIBLE = 640;
  localparam int C_H_FRONT   = 16;
  localparam int C_H_SYNC    = 96;
  localparam int C_H_BACK    = 48;
  localparam int C_V_VISIBLE = 480;
  localparam int C_V_FRONT   = 10;
  localparam int C_V_SYNC    = 2;
  localparam int C_V_BACK    = 33;
  localparam bit C_SYNC_POL  = 1'b0;
  localparam int C_CW        = 10;

  localparam int C_H_TOTAL      = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;
  localparam int C_V_TOTAL      = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;
  localparam int C_H_SYNC_START = C_H_VISIBLE + C_H_FRONT;
  localparam int C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC - 1;
  localparam int C_V_SYNC_START = C_V_VISIBLE + C_V_FRONT;
  localparam int C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC - 1;

  // Maps "inside the sync pulse" onto the physical pin level.
  function automatic logic sync_level(input logic in_pulse, input logic pol);
    return in_pulse ? pol : ~pol;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_axis_counter - one raster axis: wrapping counter plus active/sync decode
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE  = C_H_VISIBLE,
  parameter int FRONT    = C_H_FRONT,
  parameter int SYNC     = C_H_SYNC,
  parameter int BACK     = C_H_BACK,
  parameter bit SYNC_POL = C_SYNC_POL,
  parameter int CW       = C_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync_raw
);

  localparam int            C_TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CW-1:0] C_LAST       = CW'(C_TOTAL - 1);
  localparam logic [CW-1:0] C_VIS        = CW'(VISIBLE);
  localparam logic [CW-1:0] C_SYNC_START = CW'(VISIBLE + FRONT);
  localparam logic [CW-1:0] C_SYNC_END   = CW'(VISIBLE + FRONT + SYNC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap by explicit compare so non-power-of-two totals behave.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign wrap     = en && (cnt_q == C_LAST);
  assign active   = (cnt_q < C_VIS);
  assign sync_raw = sync_level((cnt_q >= C_SYNC_START) && (cnt_q <= C_SYNC_END), SYNC_POL);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_gen - VGA raster timing: registered sync, DE, coordinates, SOF
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = C_H_VISIBLE,
  parameter int H_FRONT   = C_H_FRONT,
  parameter int H_SYNC    = C_H_SYNC,
  parameter int H_BACK    = C_H_BACK,
  parameter int V_VISIBLE = C_V_VISIBLE,
  parameter int V_FRONT   = C_V_FRONT,
  parameter int V_SYNC    = C_V_SYNC,
  parameter int V_BACK    = C_V_BACK,
  parameter bit SYNC_POL  = C_SYNC_POL,
  parameter int CW        = C_CW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start
);

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_POL(SYNC_POL),  .CW(CW)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .active  (h_active),
    .sync_raw(h_sync)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_POL(SYNC_POL),  .CW(CW)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (h_wrap),
    .cnt     (v_cnt),
    .wrap    (v_wrap),
    .active  (v_active),
    .sync_raw(v_sync)
  );

  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic          frame_start_q, frame_start_d, origin_q, origin_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  // origin_q tracks "counters sit at (0,0)": true out of reset and after each frame wrap.
  always_comb begin
    de_d          = h_active && v_active;
    hsync_d       = h_sync;
    vsync_d       = v_sync;
    pix_x_d       = de_d ? h_cnt : '0;
    pix_y_d       = de_d ? v_cnt : '0;
    frame_start_d = origin_q;
    origin_d      = v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      origin_q      <= 1'b1;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      origin_q      <= origin_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_timing_gen - scoreboard bench for three raster geometries
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        d_hs, d_vs, d_de, d_fs;
  logic [9:0]  d_x, d_y;
  logic        m_hs, m_vs, m_de, m_fs;
  logic [7:0]  m_x, m_y;
  logic        s_hs, s_vs, s_de, s_fs;
  logic [3:0]  s_x, s_y;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .pix_x(d_x), .pix_y(d_y), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(5),
    .SYNC_POL(1'b0), .CW(8)
  ) u_mid (
    .clk(clk), .rst(rst), .hsync(m_hs), .vsync(m_vs), .de(m_de),
    .pix_x(m_x), .pix_y(m_y), .frame_start(m_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .CW(4)
  ) u_sml (
    .clk(clk), .rst(rst), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .pix_x(s_x), .pix_y(s_y), .frame_start(s_fs)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: position is simply the number of running edges since release,
  // folded onto the raster; every output follows from the timing rules.
  function automatic obs_t model(input int hv, input int hf, input int hs, input int hb,
                                 input int vv, input int vf, input int vs, input int vb,
                                 input bit pol, input bit in_rst, input longint n);
    obs_t   o;
    int     ht, vt, h, v;
    longint p;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (in_rst) begin
      o = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      return o;
    end
    p    = n % longint'(ht * vt);
    h    = int'(p % ht);
    v    = int'(p / ht);
    o.de = (h < hv) && (v < vv);
    o.hs = ((h >= hv + hf) && (h < hv + hf + hs)) ? pol : ~pol;
    o.vs = ((v >= vv + vf) && (v < vv + vf + vs)) ? pol : ~pol;
    o.fs = (p == 0);
    o.x  = o.de ? 16'(h) : 16'd0;
    o.y  = o.de ? 16'(v) : 16'd0;
    return o;
  endfunction

  function automatic obs_t exp_def(input bit r, input longint n);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, r, n);
  endfunction
  function automatic obs_t exp_mid(input bit r, input longint n);
    return model(40, 4, 8, 4, 30, 3, 2, 5, 1'b0, r, n);
  endfunction
  function automatic obs_t exp_sml(input bit r, input longint n);
    return model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, r, n);
  endfunction

  function automatic obs_t obs_def();
    return '{hs: d_hs, vs: d_vs, de: d_de, fs: d_fs, x: 16'(d_x), y: 16'(d_y)};
  endfunction
  function automatic obs_t obs_mid();
    return '{hs: m_hs, vs: m_vs, de: m_de, fs: m_fs, x: 16'(m_x), y: 16'(m_y)};
  endfunction
  function automatic obs_t obs_sml();
    return '{hs: s_hs, vs: s_vs, de: s_de, fs: s_fs, x: 16'(s_x), y: 16'(s_y)};
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d expected hs=%b vs=%b de=%b fs=%b x=%0d y=%0d",
               name, $time, act.hs, act.vs, act.de, act.fs, act.x, act.y,
               exp.hs, exp.vs, exp.de, exp.fs, exp.x, exp.y);
    end
  endtask

  obs_t   q_def[$], q_mid[$], q_sml[$];
  longint n_run = 0;

  // Predictor: each clock edge is a stimulus event; push what it must produce.
  always @(posedge clk) begin
    #1;
    q_def.push_back(exp_def(rst, n_run));
    q_mid.push_back(exp_mid(rst, n_run));
    q_sml.push_back(exp_sml(rst, n_run));
    if (rst) n_run = 0;
    else     n_run = n_run + 1;
  end

  // Monitor: compares away from the active edge, independent of the driver.
  always @(negedge clk) begin
    if (q_def.size() > 0) compare("def_raster", obs_def(), q_def.pop_front());
    if (q_mid.size() > 0) compare("mid_raster", obs_mid(), q_mid.pop_front());
    if (q_sml.size() > 0) compare("sml_raster", obs_sml(), q_sml.pop_front());
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic async_reset(input int hold);
    #2 rst = 1'b1;
    #1;
    compare("def_async_rst", obs_def(), exp_def(1'b1, 0));
    compare("mid_async_rst", obs_mid(), exp_mid(1'b1, 0));
    compare("sml_async_rst", obs_sml(), exp_sml(1'b1, 0));
    run_cycles(hold);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    compare("def_in_reset", obs_def(), exp_def(1'b1, 0));
    #2 rst = 1'b0;
    // Two full mid-size frames plus a few default-size lines.
    run_cycles(5000);
    for (int k = 0; k < 4; k++) begin
      async_reset(int'($urandom_range(1, 3)));
      run_cycles(int'($urandom_range(1500, 4500)));
    end
    run_cycles(3);
    checks++;
    if (q_def.size() + q_mid.size() + q_sml.size() > 1 * 3) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d allowed=3",
               q_def.size() + q_mid.size() + q_sml.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
